// File: rtl/id_operand_hazard_unit_pkg.sv
// Shared constants for the ID-stage operand hazard/forwarding scoreboard.
package id_operand_hazard_unit_pkg;

  localparam int RSIZE_DEF = 5;
  localparam int LAT_ALU   = 1;
  localparam int LAT_LOAD  = 2;
  localparam int FWD_RF    = 0;

  function automatic int sel_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/id_operand_hazard_unit_hz_operand_match.sv
// Combinational priority matcher for one ID source operand against the in-flight writer records.
module hz_operand_match
  import id_operand_hazard_unit_pkg::*;
#(
  parameter int RSIZE = RSIZE_DEF,
  parameter int DEPTH = 3,
  parameter int SELW  = 2
) (
  input  logic [DEPTH-1:0]       rec_v,
  input  logic [DEPTH*RSIZE-1:0] rec_waddr,
  input  logic [DEPTH*SELW-1:0]  rec_lat,
  input  logic [RSIZE-1:0]       raddr,
  input  logic                   ruse,
  output logic [SELW-1:0]        sel,
  output logic                   need_stall
);

  logic found;

  // Index k holds the record for stage k+1; the first hit walking up from EX is the youngest writer.
  always_comb begin
    sel        = SELW'(FWD_RF);
    need_stall = 1'b0;
    found      = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      if (!found && ruse && (raddr != '0) && rec_v[k] &&
          (rec_waddr[k*RSIZE +: RSIZE] == raddr)) begin
        found = 1'b1;
        if (rec_lat[k*SELW +: SELW] <= SELW'(k)) begin
          sel = SELW'(k + 1);
        end else begin
          need_stall = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/id_operand_hazard_unit.sv
// ID-stage hazard/forwarding scoreboard: tracks post-ID register writers and decides
// per source operand whether to forward from a later stage or stall ID.
module id_operand_hazard_unit
  import id_operand_hazard_unit_pkg::*;
#(
  parameter int RSIZE = RSIZE_DEF,
  parameter int NSRC  = 2,
  parameter int DEPTH = 3,
  parameter int CNTW  = 16,
  localparam int SELW = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  hold,
  input  logic                  flush,
  input  logic                  id_valid,
  input  logic [NSRC*RSIZE-1:0] id_raddr,
  input  logic [NSRC-1:0]       id_ruse,
  input  logic [RSIZE-1:0]      id_waddr,
  input  logic                  id_rfwen,
  input  logic [SELW-1:0]       id_lat,
  output logic                  stall,
  output logic [NSRC*SELW-1:0]  fwd_sel,
  output logic [CNTW-1:0]       stall_cnt
);

  function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
    return (v == {CNTW{1'b1}}) ? v : v + 1'b1;
  endfunction

  logic [DEPTH-1:0]       rec_v;
  logic [DEPTH*RSIZE-1:0] rec_waddr;
  logic [DEPTH*SELW-1:0]  rec_lat;
  logic [NSRC-1:0]        need_stall;
  logic [NSRC*SELW-1:0]   sel_raw;
  logic                   load_ok;

  assign load_ok = id_valid & id_rfwen & (id_waddr != '0) & ~stall & ~flush;

  // Record shift register: valid bits are the only reset state, address/latency ride along.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rec_v <= '0;
    end else if (!hold) begin
      for (int k = DEPTH - 1; k > 0; k--) begin
        rec_v[k] <= rec_v[k-1];
      end
      rec_v[0] <= load_ok;
    end
  end

  always_ff @(posedge clk) begin
    if (!hold) begin
      for (int k = DEPTH - 1; k > 0; k--) begin
        rec_waddr[k*RSIZE +: RSIZE] <= rec_waddr[(k-1)*RSIZE +: RSIZE];
        rec_lat[k*SELW +: SELW]     <= rec_lat[(k-1)*SELW +: SELW];
      end
      rec_waddr[0 +: RSIZE] <= id_waddr;
      rec_lat[0 +: SELW]    <= id_lat;
    end
  end

  for (genvar i = 0; i < NSRC; i++) begin : g_op
    hz_operand_match #(
      .RSIZE(RSIZE),
      .DEPTH(DEPTH),
      .SELW (SELW)
    ) u_match (
      .rec_v     (rec_v),
      .rec_waddr (rec_waddr),
      .rec_lat   (rec_lat),
      .raddr     (id_raddr[i*RSIZE +: RSIZE]),
      .ruse      (id_ruse[i] & id_valid),
      .sel       (sel_raw[i*SELW +: SELW]),
      .need_stall(need_stall[i])
    );

    assign fwd_sel[i*SELW +: SELW] = stall ? SELW'(FWD_RF) : sel_raw[i*SELW +: SELW];
  end

  assign stall = |need_stall;

  // Flushed ID cycles do not count as stall cycles since the environment discards them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (stall && !hold && !flush) begin
      stall_cnt <= sat_inc(stall_cnt);
    end
  end

endmodule

// File: tb/tb_id_operand_hazard_unit.sv
// Directed-vector bench for the ID operand hazard/forwarding scoreboard.
module tb_id_operand_hazard_unit;

  localparam int RSIZE = 5;
  localparam int NSRC  = 2;
  localparam int DEPTH = 3;
  localparam int CNTW  = 4;
  localparam int SELW  = 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  hold;
  logic                  flush;
  logic                  id_valid;
  logic [NSRC*RSIZE-1:0] id_raddr;
  logic [NSRC-1:0]       id_ruse;
  logic [RSIZE-1:0]      id_waddr;
  logic                  id_rfwen;
  logic [SELW-1:0]       id_lat;
  logic                  stall;
  logic [NSRC*SELW-1:0]  fwd_sel;
  logic [CNTW-1:0]       stall_cnt;

  int vec_cnt = 0;
  int err_cnt = 0;

  id_operand_hazard_unit #(
    .RSIZE(RSIZE),
    .NSRC (NSRC),
    .DEPTH(DEPTH),
    .CNTW (CNTW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .hold     (hold),
    .flush    (flush),
    .id_valid (id_valid),
    .id_raddr (id_raddr),
    .id_ruse  (id_ruse),
    .id_waddr (id_waddr),
    .id_rfwen (id_rfwen),
    .id_lat   (id_lat),
    .stall    (stall),
    .fwd_sel  (fwd_sel),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one ID cycle, then let combinational outputs settle before checking.
  task automatic drive(input logic v, input logic [RSIZE-1:0] r0, input logic [RSIZE-1:0] r1,
                       input logic [1:0] use_, input logic wen, input logic [RSIZE-1:0] wa,
                       input logic [SELW-1:0] lat, input logic fl, input logic hd);
    id_valid = v;
    id_raddr = {r1, r0};
    id_ruse  = use_;
    id_rfwen = wen;
    id_waddr = wa;
    id_lat   = lat;
    flush    = fl;
    hold     = hd;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 5'd0, 2'b00, 1'b0, 5'd0, 2'd0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    step();
    step();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    drive(1'b1, 5'd5, 5'd6, 2'b11, 1'b0, 5'd0, 2'd0, 1'b0, 1'b0);
    vec_cnt++;
    if (stall !== 1'b0) begin err_cnt++; $display("FAIL reset_stall got %b want 0", stall); end
    vec_cnt++;
    if (fwd_sel !== 4'h0) begin err_cnt++; $display("FAIL reset_fwd got %h want 0", fwd_sel); end
    vec_cnt++;
    if (stall_cnt !== 4'd0) begin err_cnt++; $display("FAIL reset_cnt got %0d want 0", stall_cnt); end
  endtask

  task automatic test_alu_fwd();
    do_reset();
    drive(1'b1, 5'd0, 5'd0, 2'b00, 1'b1, 5'd5, 2'd1, 1'b0, 1'b0);
    step();
    drive(1'b1, 5'd5, 5'd0, 2'b01, 1'b0, 5'd0, 2'd0, 1'b0, 1'b0);
    vec_cnt++;
    if (stall !== 1'b1 || fwd_sel !== 4'h0) begin
      err_cnt++; $display("FAIL alu_c1 got stall=%b fwd=%h want stall=1 fwd=0", stall, fwd_sel);
    end
    step();
    vec_cnt++;
    if (stall !== 1'b0 || fwd_sel !== 4'h2) begin
      err_cnt++; $display("FAIL alu_c2 got stall=%b fwd=%h want stall=0 fwd=2", stall, fwd_sel);
    end
    vec_cnt++;
    if (stall_cnt !== 4'd1) begin err_cnt++; $display("FAIL alu_cnt got %0d want 1", stall_cnt); end
  endtask

  task automatic test_load_stall();
    do_reset();
    drive(1'b1, 5'd0, 5'd0, 2'b00, 1'b1, 5'd7, 2'd2, 1'b0, 1'b0);
    step();
    drive(1'b1, 5'd7, 5'd0, 2'b01, 1'b0, 5'd0, 2'd0, 1'b0, 1'b0);
    vec_cnt++;
    if (stall !== 1'b1) begin err_cnt++; $display("FAIL load_c1 got stall=%b want 1", stall); end
    step();
    vec_cnt++;
    if (stall !== 1'b1 || fwd_sel !== 4'h0) begin
      err_cnt++; $display("FAIL load_c2 got stall=%b fwd=%h want stall=1 fwd=0", stall, fwd_sel);
    end
    step();
    vec_cnt++;
    if (stall !== 1'b0 || fwd_sel !== 4'h3) begin
      err_cnt++; $display("FAIL load_c3 got stall=%b fwd=%h want stall=0 fwd=3", stall, fwd_sel);
    end
    vec_cnt++;
    if (stall_cnt !== 4'd2) begin err_cnt++; $display("FAIL load_cnt got %0d want 2", stall_cnt); end
  endtask

  task automatic test_r0();
    do_reset();
    drive(1'b1, 5'd0, 5'd0, 2'b00, 1'b1, 5'd0, 2'd1, 1'b0, 1'b0);
    step();
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 5'd0, 5'd0, 2'b11, 1'b0, 5'd0, 2'd0, 1'b0, 1'b0);
      vec_cnt++;
      if (stall !== 1'b0 || fwd_sel !== 4'h0) begin
        err_cnt++; $display("FAIL r0_c%0d got stall=%b fwd=%h want 0/0", c, stall, fwd_sel);
      end
      step();
    end
  endtask

  task automatic test_youngest();
    do_reset();
    drive(1'b1, 5'd0, 5'd0, 2'b00, 1'b1, 5'd3, 2'd1, 1'b0, 1'b0);
    step();
    drive(1'b1, 5'd0, 5'd0, 2'b00, 1'b1, 5'd3, 2'd1, 1'b0, 1'b0);
    step();
    idle();
    step();
    drive(1'b1, 5'd3, 5'd0, 2'b01, 1'b0, 5'd0, 2'd0, 1'b0, 1'b0);
    vec_cnt++;
    if (stall !== 1'b0 || fwd_sel !== 4'h2) begin
      err_cnt++; $display("FAIL youngest got stall=%b fwd=%h want stall=0 fwd=2", stall, fwd_sel);
    end
  endtask

  task automatic test_dual();
    do_reset();
    drive(1'b1, 5'd0, 5'd0, 2'b00, 1'b1, 5'd4, 2'd1, 1'b0, 1'b0);
    step();
    drive(1'b1, 5'd0, 5'd0, 2'b00, 1'b1, 5'd6, 2'd1, 1'b0, 1'b0);
    step();
    drive(1'b1, 5'd4, 5'd6, 2'b11, 1'b0, 5'd0, 2'd0, 1'b0, 1'b0);
    vec_cnt++;
    if (stall !== 1'b1 || fwd_sel !== 4'h0) begin
      err_cnt++; $display("FAIL dual_c1 got stall=%b fwd=%h want stall=1 fwd=0", stall, fwd_sel);
    end
    step();
    vec_cnt++;
    if (stall !== 1'b0 || fwd_sel !== 4'hB) begin
      err_cnt++; $display("FAIL dual_c2 got stall=%b fwd=%h want stall=0 fwd=b", stall, fwd_sel);
    end
  endtask

  task automatic test_hold_rst();
    do_reset();
    drive(1'b1, 5'd0, 5'd0, 2'b00, 1'b1, 5'd7, 2'd2, 1'b0, 1'b0);
    step();
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 5'd7, 5'd0, 2'b01, 1'b0, 5'd0, 2'd0, 1'b0, 1'b1);
      vec_cnt++;
      if (stall !== 1'b1 || stall_cnt !== 4'd0) begin
        err_cnt++; $display("FAIL hold_c%0d got stall=%b cnt=%0d want 1/0", c, stall, stall_cnt);
      end
      step();
    end
    drive(1'b1, 5'd7, 5'd0, 2'b01, 1'b0, 5'd0, 2'd0, 1'b0, 1'b0);
    vec_cnt++;
    if (stall !== 1'b1 || stall_cnt !== 4'd0) begin
      err_cnt++; $display("FAIL hold_rel got stall=%b cnt=%0d want 1/0", stall, stall_cnt);
    end
    step();
    vec_cnt++;
    if (stall !== 1'b1 || stall_cnt !== 4'd1) begin
      err_cnt++; $display("FAIL hold_s2 got stall=%b cnt=%0d want 1/1", stall, stall_cnt);
    end
    #2;
    rst = 1'b1;
    #1;
    vec_cnt++;
    if (stall !== 1'b0 || stall_cnt !== 4'd0) begin
      err_cnt++; $display("FAIL midrst got stall=%b cnt=%0d want 0/0", stall, stall_cnt);
    end
    rst = 1'b0;
  endtask

  task automatic test_flush();
    do_reset();
    drive(1'b1, 5'd0, 5'd0, 2'b00, 1'b1, 5'd5, 2'd1, 1'b1, 1'b0);
    step();
    drive(1'b1, 5'd5, 5'd0, 2'b01, 1'b0, 5'd0, 2'd0, 1'b0, 1'b0);
    vec_cnt++;
    if (stall !== 1'b0 || fwd_sel !== 4'h0) begin
      err_cnt++; $display("FAIL flush_norec got stall=%b fwd=%h want 0/0", stall, fwd_sel);
    end
    drive(1'b1, 5'd0, 5'd0, 2'b00, 1'b1, 5'd5, 2'd1, 1'b0, 1'b0);
    step();
    drive(1'b1, 5'd5, 5'd0, 2'b01, 1'b0, 5'd0, 2'd0, 1'b1, 1'b0);
    vec_cnt++;
    if (stall !== 1'b1) begin err_cnt++; $display("FAIL flush_stall got %b want 1", stall); end
    step();
    vec_cnt++;
    if (stall_cnt !== 4'd0) begin err_cnt++; $display("FAIL flush_cnt got %0d want 0", stall_cnt); end
    drive(1'b1, 5'd0, 5'd5, 2'b10, 1'b0, 5'd0, 2'd0, 1'b0, 1'b0);
    vec_cnt++;
    if (stall !== 1'b0 || fwd_sel !== 4'h8) begin
      err_cnt++; $display("FAIL flush_fwd got stall=%b fwd=%h want 0/8", stall, fwd_sel);
    end
  endtask

  task automatic test_oor_sat();
    do_reset();
    for (int it = 0; it < 6; it++) begin
      drive(1'b1, 5'd0, 5'd0, 2'b00, 1'b1, 5'd9, 2'd3, 1'b0, 1'b0);
      step();
      for (int c = 0; c < 4; c++) begin
        drive(1'b1, 5'd9, 5'd0, 2'b01, 1'b0, 5'd0, 2'd0, 1'b0, 1'b0);
        vec_cnt++;
        if (stall !== (c < 3) || fwd_sel !== 4'h0) begin
          err_cnt++;
          $display("FAIL oor_i%0d_c%0d got stall=%b fwd=%h want stall=%b fwd=0",
                   it, c, stall, fwd_sel, (c < 3));
        end
        step();
      end
    end
    vec_cnt++;
    if (stall_cnt !== 4'd15) begin err_cnt++; $display("FAIL sat_cnt got %0d want 15", stall_cnt); end
  endtask

  initial begin
    rst = 1'b1;
    hold = 1'b0;
    flush = 1'b0;
    id_valid = 1'b0;
    id_raddr = '0;
    id_ruse = '0;
    id_waddr = '0;
    id_rfwen = 1'b0;
    id_lat = '0;
    test_reset();
    test_alu_fwd();
    test_load_stall();
    test_r0();
    test_youngest();
    test_dual();
    test_hold_rst();
    test_flush();
    test_oor_sat();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
